// File: rtl/bram_window_reader_pkg.sv
// Shared widths, address layout and FSM encoding for the acquisition BRAM window reader.
package bram_window_reader_pkg;

    localparam int WORD_W    = 32;
    localparam int SAMPLE_W  = 14;
    localparam int ADDR_STEP = 4;
    localparam int ADDR_LSB  = $clog2(ADDR_STEP);
    localparam int CNT_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A well-formed word is a sign-extended sample: bits above the sample all copy its MSB.
    function automatic logic is_sign_ext(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:SAMPLE_W] == {(WORD_W-SAMPLE_W){w[SAMPLE_W-1]}};
    endfunction

endpackage

// File: rtl/bram_window_reader_sync_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is read straight from the storage registers.
module sync_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_rd;

    assign do_rd     = rd_en_i && (count_q != '0);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

    always_comb begin
        count_d = count_q;
        case ({wr_en_i, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(wr_en_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/bram_window_reader.sv
// Streams an N-sample window out of the acquisition BRAM with credit-based read issue.
// IDLE: wait for start | ISSUE: credit-limited reads | DRAIN: wait for last sample | DONE: one-cycle done
module bram_window_reader
    import bram_window_reader_pkg::*;
#(
    parameter int BRAM_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_start,
    input  logic [CNT_W-1:0]    i10_window_length,
    output logic [WORD_W-1:0]   or32_bram_add,
    output logic                o_bram_en,
    output logic [3:0]          or4_bram_we,
    output logic                o_bram_rst,
    input  logic [WORD_W-1:0]   i32_bram_data,
    output logic [SAMPLE_W-1:0] o14_data,
    output logic                o_data_valid,
    input  logic                i_data_ready,
    output logic                o_data_last,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_format_error
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d, k_q, k_d;
    logic [CW-1:0]       inflight_q, inflight_d, fifo_count;
    logic [BRAM_LATENCY-1:0] tag_v_q, tag_l_q;
    logic                fmt_err_q, fmt_err_d;
    logic                issue, issue_last, start_ok, credit_ok;
    logic                fifo_wr, fifo_empty, pop, fifo_last;
    logic [SAMPLE_W-1:0] fifo_data;

    // Reads in flight plus buffered samples never exceed the FIFO, so every return has a slot.
    assign credit_ok = (inflight_q + fifo_count) < CW'(FIFO_DEPTH);
    assign fifo_wr   = tag_v_q[BRAM_LATENCY-1];
    assign pop       = !fifo_empty && i_data_ready;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        k_d        = k_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        start_ok   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && (i10_window_length != '0)) begin
                    start_ok = 1'b1;
                    len_d    = i10_window_length;
                    k_d      = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (k_q == len_q - CNT_W'(1)) begin
                        issue_last = 1'b1;
                        state_d    = ST_DRAIN;
                    end else begin
                        k_d = k_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if ((inflight_q == '0) &&
                    ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop)))
                    state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, fifo_wr})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        fmt_err_d = fmt_err_q;
        if (start_ok)
            fmt_err_d = 1'b0;
        else if (fifo_wr && !is_sign_ext(i32_bram_data))
            fmt_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            k_q        <= '0;
            inflight_q <= '0;
            tag_v_q    <= '0;
            tag_l_q    <= '0;
            fmt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            k_q        <= k_d;
            inflight_q <= inflight_d;
            fmt_err_q  <= fmt_err_d;
            tag_v_q[0] <= issue;
            tag_l_q[0] <= issue_last;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_l_q[i] <= tag_l_q[i-1];
            end
        end
    end

    sync_fifo #(
        .WIDTH (SAMPLE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (fifo_wr),
        .wr_data_i ({tag_l_q[BRAM_LATENCY-1], i32_bram_data[SAMPLE_W-1:0]}),
        .rd_en_i   (i_data_ready),
        .rd_data_o ({fifo_last, fifo_data}),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign or32_bram_add  = {{(WORD_W-CNT_W-ADDR_LSB){1'b0}}, k_q, {ADDR_LSB{1'b0}}};
    assign o_bram_en      = issue;
    assign or4_bram_we    = 4'b0000;
    assign o_bram_rst     = !rstn;
    assign o14_data       = fifo_data;
    assign o_data_last    = fifo_last;
    assign o_data_valid   = !fifo_empty;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_done         = (state_q == ST_DONE);
    assign o_format_error = fmt_err_q;

endmodule

// File: tb/tb_bram_window_reader.sv
// Directed bench: BRAM model, window-level expectation queue checked every cycle, literal timing pins.
module tb_bram_window_reader;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_start = 1'b0;
    logic [9:0]  len = '0;
    logic        i_data_ready = 1'b0;
    logic [31:0] i32_bram_data = '0;
    logic [31:0] or32_bram_add;
    logic        o_bram_en, o_bram_rst, o_data_valid, o_data_last;
    logic        o_busy, o_done, o_format_error;
    logic [3:0]  or4_bram_we;
    logic [13:0] o14_data;

    bram_window_reader #(.BRAM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .i_start           (i_start),
        .i10_window_length (len),
        .or32_bram_add     (or32_bram_add),
        .o_bram_en         (o_bram_en),
        .or4_bram_we       (or4_bram_we),
        .o_bram_rst        (o_bram_rst),
        .i32_bram_data     (i32_bram_data),
        .o14_data          (o14_data),
        .o_data_valid      (o_data_valid),
        .i_data_ready      (i_data_ready),
        .o_data_last       (o_data_last),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_format_error    (o_format_error)
    );

    always #5 clk = ~clk;

    // Two-stage read pipeline; garbage when not enabled so misaligned captures show up.
    logic [31:0] mem [1024];
    logic [31:0] bram_p1 = '0;
    always @(posedge clk) begin
        bram_p1       <= o_bram_en ? mem[or32_bram_add[11:2]] : 32'hA5A5_5A5A;
        i32_bram_data <= bram_p1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Window model: what must come out, in what order, and when.
    logic [14:0] exp_q[$];
    logic [14:0] w, prev_word;
    logic [13:0] got_d [1024];
    bit          active = 0, done_flag = 0, prev_stall = 0, seen_en = 0, seen_val = 0;
    int          t_start = 0, issued = 0, consumed = 0, last_hs = 0, done_cyc = 0;
    int          got_n = 0, done_cnt = 0, last_addr = 0, n_req = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            active     = 0;
            prev_stall = 0;
        end else begin
            chk("bram_we", int'(or4_bram_we), 0);
            chk("bram_rst", int'(o_bram_rst), 0);
            chk("busy", int'(o_busy), int'(active && cyc >= t_start));
            if (o_bram_en) begin
                chk("en_in_window", int'(active && cyc >= t_start), 1);
                chk("addr", int'(or32_bram_add), issued * 4);
                chk("credit", int'((issued - consumed) < DEPTH), 1);
                if (!seen_en) chk("first_en_lat", cyc - t_start, 0);
                seen_en   = 1;
                last_addr = int'(or32_bram_add);
                issued++;
            end
            if (prev_stall) begin
                chk("hold_valid", int'(o_data_valid), 1);
                chk("hold_word", int'({o_data_last, o14_data}), int'(prev_word));
            end
            if (o_data_valid && !seen_val) begin
                chk("first_valid_lat", cyc - t_start, LAT + 1);
                seen_val = 1;
            end
            if (o_data_valid && i_data_ready) begin
                chk("sample_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk("data", int'(o14_data), int'(w[13:0]));
                    chk("last", int'(o_data_last), int'(w[14]));
                end
                got_d[got_n] = o14_data;
                got_n++;
                consumed++;
                last_hs = cyc;
            end
            prev_stall = o_data_valid && !i_data_ready;
            prev_word  = {o_data_last, o14_data};
            if (o_done) begin
                chk("done_after_last", cyc - last_hs, 1);
                chk("done_queue_empty", exp_q.size(), 0);
                done_flag = 1;
                done_cnt++;
                done_cyc = cyc;
                active   = 0;
            end
            if (i_start && !active && len != '0) begin
                n_req = int'(len);
                for (int k = 0; k < n_req; k++)
                    exp_q.push_back({(k == n_req - 1), mem[k][13:0]});
                active    = 1;
                t_start   = cyc + 1;
                issued    = 0;
                consumed  = 0;
                got_n     = 0;
                seen_en   = 0;
                seen_val  = 0;
                done_flag = 0;
            end
        end
    end

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        i_start = 1'b1;
        len     = 10'(n);
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // mode 0: ready high, 1: toggle 1-0, 2: random
    task automatic run(input int mode, input int budget);
        int c;
        c = 0;
        while (!done_flag && c < budget) begin
            @(posedge clk); #1;
            case (mode)
                0:       i_data_ready = 1'b1;
                1:       i_data_ready = (c % 2 == 0);
                default: i_data_ready = 1'($urandom_range(0, 1));
            endcase
            c++;
        end
        chk("window_completes", int'(done_flag), 1);
        @(posedge clk); #1;
        i_data_ready = 1'b1;
    endtask

    int d0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i - 4);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_valid", int'(o_data_valid), 0);
        chk("rst_en", int'(o_bram_en), 0);
        chk("rst_addr", int'(or32_bram_add), 0);
        chk("rst_bram_rst", int'(o_bram_rst), 1);
        chk("rst_fmt", int'(o_format_error), 0);
        rstn = 1'b1;

        // N=8 streaming ramp, no backpressure
        i_data_ready = 1'b1;
        pulse_start(8);
        run(0, 100);
        chk("n8_last_hs", last_hs - t_start, 10);
        chk("n8_done", done_cyc - t_start, 11);
        chk("n8_count", got_n, 8);
        chk("n8_first", int'(got_d[0]), 'h3FFC);
        chk("n8_final", int'(got_d[7]), 'h0003);
        chk("n8_last_addr", last_addr, 28);

        // N=16 under toggling and random backpressure
        pulse_start(16);
        run(1, 300);
        chk("n16_toggle_count", got_n, 16);
        pulse_start(16);
        run(2, 600);
        chk("n16_random_count", got_n, 16);
        chk("n16_random_final", int'(got_d[15]), 'h000B);

        // N=1 and N=0
        pulse_start(1);
        run(0, 50);
        chk("n1_count", got_n, 1);
        chk("n1_data", int'(got_d[0]), 'h3FFC);
        chk("n1_done", done_cyc - t_start, 4);
        d0 = done_cnt;
        pulse_start(0);
        repeat (5) @(negedge clk);
        chk("n0_busy", int'(o_busy), 0);
        chk("n0_no_done", done_cnt, d0);

        // malformed word at address 8
        mem[2] = 32'h0001_2000;
        pulse_start(4);
        run(0, 50);
        repeat (3) @(negedge clk);
        chk("fmt_set", int'(o_format_error), 1);
        chk("fmt_sample", int'(got_d[2]), 'h2000);
        mem[2] = 32'(2 - 4);
        pulse_start(1);
        chk("fmt_cleared", int'(o_format_error), 0);
        run(0, 50);
        chk("fmt_stays_clear", int'(o_format_error), 0);

        // reset in the middle of an N=32 window
        pulse_start(32);
        d0 = 0;
        while (got_n < 5 && d0 < 200) begin
            @(posedge clk);
            d0++;
        end
        chk("rst_mid_progress", int'(got_n >= 5), 1);
        #1;
        d0   = done_cnt;
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", int'(o_data_valid), 0);
        chk("mid_rst_en", int'(o_bram_en), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_addr", int'(or32_bram_add), 0);
        chk("mid_rst_data", int'({o_data_last, o14_data}), 0);
        chk("mid_rst_bram_rst", int'(o_bram_rst), 1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        chk("mid_rst_no_done", done_cnt, d0);
        pulse_start(2);
        run(0, 50);
        chk("after_rst_count", got_n, 2);
        chk("after_rst_first", int'(got_d[0]), 'h3FFC);

        // start pulse while busy is ignored
        pulse_start(6);
        repeat (2) @(posedge clk);
        pulse_start(3);
        run(2, 300);
        chk("restart_count", got_n, 6);
        chk("restart_final", int'(got_d[5]), 'h0001);

        // longest window, no address wrap
        pulse_start(1023);
        run(0, 1200);
        chk("n1023_count", got_n, 1023);
        chk("n1023_last_addr", last_addr, 4088);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_window_reader.md
# bram_window_reader

Reads a captured sample window back out of the acquisition BRAM and streams it, one sample per handshake, to the downstream processing chain (Goertzel filter input). It is the read side of the acquisition BRAM: the acquisition controller writes sign-extended 14-bit ADC samples as 32-bit words at byte addresses 0, 4, 8, …; this block issues the matching reads, absorbs BRAM read latency and downstream backpressure, and marks the last sample of each window.

## Interface
Parameters:
- BRAM_LATENCY, 2, cycles from en/address edge to valid i32_bram_data (1..3)
- FIFO_DEPTH, 4, output buffer depth in samples; must be ≥ BRAM_LATENCY+2, power of two

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- i_start  in  1  start-of-window request, one-cycle pulse
- i10_window_length  in  10  samples per window N; sampled on the accepted i_start
- or32_bram_add  out  32  BRAM byte address
- o_bram_en  out  1  BRAM read enable, high only on issue cycles
- or4_bram_we  out  4  BRAM write enable, constant 4'b0000
- o_bram_rst  out  1  BRAM reset, = !rstn
- i32_bram_data  in  32  BRAM read data
- o14_data  out  14  sample, = word[13:0]
- o_data_valid  out  1  sample valid
- i_data_ready  in  1  downstream accepts sample
- o_data_last  out  1  high with the final sample of the window
- o_busy  out  1  window in progress
- o_done  out  1  one-cycle pulse after final handshake
- o_format_error  out  1  sticky: a read word had bits [31:14] ≠ replicated bit 13; cleared on accepted i_start

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: i_start with i10_window_length ≠ 0 latches N, clears address counter and o_format_error, → ISSUE. i_start with N = 0 ignored. i_start outside IDLE ignored.
- ISSUE: each cycle, issue one read (o_bram_en=1, or32_bram_add = 4·k, k = 0..N−1) iff in-flight reads + FIFO occupancy < FIFO_DEPTH. After issuing k = N−1 → DRAIN.
- Return path: BRAM_LATENCY-deep shift register of {valid, last} tags aligned with issued reads; tagged data written into FIFO with its last bit.
- DRAIN: wait until no reads in flight and FIFO empty → DONE.
- DONE: assert o_done for one cycle → IDLE.
- o_busy = state ≠ IDLE.
- Output handshake: sample transfers on the edge where o_data_valid & i_data_ready; o14_data/o_data_last held stable while valid & !ready. o_data_valid never drops without a handshake.
- Credit rule guarantees FIFO never overflows; write into full FIFO is a design error (assertion).
- Address width: counter 10 bits, address = {20'b0, k, 2'b00}.

## Timing
- Reset (async assert, sync-release by system): state IDLE, or32_bram_add=0, o_bram_en=0, or4_bram_we=0, o_data_valid=0, o_data_last=0, o14_data=0, o_busy=0, o_done=0, o_format_error=0; in-flight reads and FIFO contents discarded. Reset mid-window aborts it; no o_done.
- i_start sampled at edge t → first o_bram_en at cycle t+1 → data captured into FIFO at edge t+1+BRAM_LATENCY → o_data_valid high from t+2+BRAM_LATENCY.
- With i_data_ready held high: one read issued per cycle, one sample per cycle, no bubbles; last handshake at edge t+1+BRAM_LATENCY+N; o_done high the following cycle; o_busy falls with o_done.
- Backpressure: issue stalls the cycle credit is exhausted; resumes the cycle after a handshake frees credit.
- N = 1: single sample with o_data_last=1.
- N = 1023: final address 4088, no wrap.

## Structure
- Shared package: BRAM word width (32), sample width (14), address step (4), FSM state encoding.
- Sub-module: sync_fifo (parameterised width/depth, registered output, count output) holds {last, data[13:0]}.

## Test plan
- N=8, ready high, BRAM preloaded sign-extended ramp −4..3 → addresses 0,4,…,28 on consecutive cycles; outputs 0x3FFC,0x3FFD,…,0x0003; last on 8th; o_done once; first valid at t+4.
- N=16, ready toggled 1-0-1-0 and random → all 16 samples in order, none duplicated/lost, data stable during stalls, o_bram_en never exceeds credit.
- N=1 → one read at address 0, one sample with last=1, o_done 1 cycle later; N=0 start → no reads, o_busy stays 0.
- Word 0x0001_2000 at address 8 in N=4 window → o_format_error set and held after o_done; cleared by next i_start.
- rstn pulsed low at sample 5 of N=32 → all outputs reset immediately, no o_done; fresh i_start after release reads from address 0.
- i_start re-pulsed while busy → ignored, current window completes unchanged.
